tpic2mem: RTL and testbench

//  Receiving end of the TPIC serial relay-driver link: deserializes the sclk/sout/rck/en_n

---
 rtl/tpic2mem.sv | 143 ++++++++++++++
 tb/tb_tpic2mem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpic2mem.sv
// ============================================================================
// Module      : tpic2mem
// Description : TPIC serial link receiver. Synchronizes the asynchronous
//               sclk/sin/rck/en_n link, shifts bits LSB first, and rebuilds
//               the parallel word on each rck rising edge. Frames with a
//               bad bit count, with en_n high, or with an sclk/rck collision
//               raise frame_err and advance a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tpic2mem #(
  parameter int WIDTH = 16,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_in,
  input  logic             sin,
  input  logic             rck_in,
  input  logic             en_n_in,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt
);

  // bit_cnt must hold 0..WIDTH+1 so an over-long frame stays distinguishable
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_CNT_SAT  = CNT_W'(WIDTH + 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_LATCH = 2'd2;

  logic [2:0]       r_sclk_sync;
  logic [2:0]       r_rck_sync;
  logic [1:0]       r_sin_sync;
  logic [1:0]       r_en_n_sync;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_frame_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic w_sclk_rise;
  logic w_rck_rise;
  logic w_sin;
  logic w_en_n;
  logic w_good;

  // Two-flop synchronizers; sclk/rck get a third stage for edge detection.
  // sin uses the same depth as sclk so the sampled bit lines up with the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= 3'b000;
      r_rck_sync  <= 3'b000;
      r_sin_sync  <= 2'b00;
      r_en_n_sync <= 2'b11;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk_in};
      r_rck_sync  <= {r_rck_sync[1:0], rck_in};
      r_sin_sync  <= {r_sin_sync[0], sin};
      r_en_n_sync <= {r_en_n_sync[0], en_n_in};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_rck_rise  = r_rck_sync[1] & ~r_rck_sync[2];
  assign w_sin       = r_sin_sync[1];
  assign w_en_n      = r_en_n_sync[1];

  // A frame is good only inside an enabled frame with exactly WIDTH bits and
  // no shift edge colliding with the latch edge.
  assign w_good = (r_state == c_ST_SHIFT) & ~w_en_n & (r_bit_cnt == c_CNT_FULL) & ~w_sclk_rise;

  // Link state: IDLE while disabled, SHIFT while enabled, LATCH for the one
  // clock that emits the end-of-frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else if (w_rck_rise) begin
      r_state <= c_ST_LATCH;
    end else if (w_en_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= c_ST_SHIFT;
    end
  end

  // Shift register and bit counter; a latch edge always restarts the count
  // and discards any shift edge arriving in the same clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (w_rck_rise) begin
      r_bit_cnt <= '0;
    end else if (w_en_n) begin
      r_bit_cnt <= '0;
    end else if (w_sclk_rise) begin
      r_sreg <= {w_sin, r_sreg[WIDTH-1:1]};
      if (r_bit_cnt != c_CNT_SAT) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Frame-end outputs: publish a good word or flag and count the error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_rck_rise) begin
        if (w_good) begin
          r_data       <= r_sreg;
          r_data_valid <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
          if (!(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign err_cnt    = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tpic2mem.sv
// ============================================================================
// Module      : tb_tpic2mem
// Description : Self-checking bench for tpic2mem (WIDTH=16) with a second
//               instance (ERR_W=2) for error-counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tpic2mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset2 = 1'b1;
  logic        sclk_in = 1'b0;
  logic        sin = 1'b0;
  logic        rck_in = 1'b0;
  logic        en_n_in = 1'b1;
  logic [15:0] data;
  logic        data_valid;
  logic        frame_err;
  logic [15:0] err_cnt;
  logic [15:0] data2;
  logic        data_valid2;
  logic        frame_err2;
  logic [1:0]  err_cnt2;

  int checks = 0;
  int errors = 0;
  int nv = 0;
  int ne = 0;
  int nboth = 0;

  always #5 clk = ~clk;

  tpic2mem #(.WIDTH(16), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .sclk_in(sclk_in), .sin(sin), .rck_in(rck_in),
    .en_n_in(en_n_in), .data(data), .data_valid(data_valid),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  tpic2mem #(.WIDTH(16), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset2), .sclk_in(sclk_in), .sin(sin), .rck_in(rck_in),
    .en_n_in(en_n_in), .data(data2), .data_valid(data_valid2),
    .frame_err(frame_err2), .err_cnt(err_cnt2)
  );

  // Pulse counters sampled mid-cycle; each one-clock pulse is seen once.
  always @(negedge clk) begin
    if (data_valid) nv = nv + 1;
    if (frame_err) ne = ne + 1;
    if (data_valid && frame_err) nboth = nboth + 1;
  end

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic        en_n;
    logic        do_rck;
    logic [15:0] exp_data;
    int          exp_v;
    int          exp_e;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Serializer-style frame: 2 clk per sclk phase, sin set a full phase
  // before the rise and held through the high phase.
  task automatic link_frame(input logic [15:0] w, input int n, input logic en, input logic do_rck);
    en_n_in = en;
    for (int i = 0; i < n; i++) begin
      sin = w[i % 16];
      sclk_in = 1'b0;
      tick(2);
      sclk_in = 1'b1;
      tick(2);
    end
    sclk_in = 1'b0;
    tick(2);
    if (do_rck) begin
      rck_in = 1'b1;
      tick(2);
      rck_in = 1'b0;
      tick(2);
    end
    en_n_in = 1'b1;
    tick(4);
  endtask

  initial begin
    vecs[0] = '{16'hAAAA, 16, 1'b0, 1'b1, 16'hAAAA, 1, 0, 16'd0};
    vecs[1] = '{16'h00FF, 15, 1'b0, 1'b1, 16'hAAAA, 0, 1, 16'd1};
    vecs[2] = '{16'h00FF, 17, 1'b0, 1'b1, 16'hAAAA, 0, 1, 16'd2};
    vecs[3] = '{16'h5555, 16, 1'b0, 1'b1, 16'h5555, 1, 0, 16'd2};
    vecs[4] = '{16'h00FF,  8, 1'b1, 1'b0, 16'h5555, 0, 0, 16'd2};
    vecs[5] = '{16'hC3A5, 16, 1'b0, 1'b1, 16'hC3A5, 1, 0, 16'd2};
    vecs[6] = '{16'h1111, 16, 1'b1, 1'b1, 16'hC3A5, 0, 1, 16'd3};
    vecs[7] = '{16'hFFFF, 16, 1'b0, 1'b1, 16'hFFFF, 1, 0, 16'd3};

    tick(3);
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    chk("reset_errcnt", 32'(err_cnt), 32'h0);
    reset = 1'b0;
    tick(2);

    for (int k = 0; k < 8; k++) begin
      nv = 0;
      ne = 0;
      link_frame(vecs[k].word, vecs[k].nbits, vecs[k].en_n, vecs[k].do_rck);
      chk($sformatf("v%0d_data", k), 32'(data), 32'(vecs[k].exp_data));
      chk($sformatf("v%0d_valid_pulses", k), 32'(nv), 32'(vecs[k].exp_v));
      chk($sformatf("v%0d_err_pulses", k), 32'(ne), 32'(vecs[k].exp_e));
      chk($sformatf("v%0d_errcnt", k), 32'(err_cnt), 32'(vecs[k].exp_cnt));
    end

    // Reset in the middle of a frame clears outputs immediately.
    en_n_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin = 1'b1;
      sclk_in = 1'b0;
      tick(2);
      sclk_in = 1'b1;
      tick(2);
    end
    #2 reset = 1'b1;
    #1;
    chk("midreset_data", 32'(data), 32'h0);
    chk("midreset_errcnt", 32'(err_cnt), 32'h0);
    chk("midreset_valid", 32'(data_valid), 32'h0);
    chk("midreset_err", 32'(frame_err), 32'h0);
    sclk_in = 1'b0;
    en_n_in = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);

    // Full frame after reset, with rck-to-data latency checked edge by edge.
    nv = 0;
    ne = 0;
    en_n_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sin = (i == 2 || i == 4 || i == 5 || i == 9 || i == 12) ? 1'b1 : 1'b0;
      sclk_in = 1'b0;
      tick(2);
      sclk_in = 1'b1;
      tick(2);
    end
    sclk_in = 1'b0;
    tick(2);
    rck_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lat_edge2_valid", 32'(data_valid), 32'h0);
    @(posedge clk); #1;
    chk("lat_edge3_valid", 32'(data_valid), 32'h1);
    chk("lat_edge3_data", 32'(data), 32'h1234);
    @(negedge clk);
    rck_in = 1'b0;
    tick(2);
    en_n_in = 1'b1;
    tick(4);
    chk("f1234_valid_pulses", 32'(nv), 32'd1);
    chk("f1234_err_pulses", 32'(ne), 32'd0);

    // 17th sclk rise lands in the same clock as rck rise: shift dropped, error.
    nv = 0;
    ne = 0;
    en_n_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sin = i[0];
      sclk_in = 1'b0;
      tick(2);
      sclk_in = 1'b1;
      tick(2);
    end
    sclk_in = 1'b0;
    sin = 1'b0;
    tick(2);
    sclk_in = 1'b1;
    rck_in = 1'b1;
    tick(2);
    sclk_in = 1'b0;
    rck_in = 1'b0;
    tick(2);
    en_n_in = 1'b1;
    tick(4);
    chk("collide_err_pulses", 32'(ne), 32'd1);
    chk("collide_valid_pulses", 32'(nv), 32'd0);
    chk("collide_data", 32'(data), 32'h1234);
    chk("collide_errcnt", 32'(err_cnt), 32'd1);

    // Saturating 2-bit error counter.
    reset2 = 1'b0;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      link_frame(16'h0000, 15, 1'b0, 1'b1);
      chk($sformatf("sat_errcnt_%0d", k), 32'(err_cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
    end

    chk("valid_err_overlap", 32'(nboth), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
